msi_irq_axi_master: RTL and testbench

Multi-vector MSI generator that turns per-vector interrupt requests into single-beat AXI4 posted writes on the PCIe controller's master AXI port. It supersedes the single-shot VIO-driven MSI test master. It adds parametrised data width and vector count, MSI multiple-message data encoding, round-robin arbitration, masking, and proper B-channel completion with error accounting. It sits between user interrupt sources and the controller's master AXI write channels; the read channels are not used.

---
 rtl/msi_irq_axi_master.sv | 230 +++++++++++++++++++++++
 tb/tb_msi_irq_axi_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_irq_axi_master.sv
// msi_irq_axi_master: multi-vector MSI generator issuing single-beat AXI4
// posted writes. Per-vector request edges latch pending bits. A round-robin
// arbiter grants unmasked pending vectors one at a time. Each grant becomes
// one AW+W write, and the B response retires it and counts errors.
// Optional build macro MSI_AXI_PARITY_EN: odd byte parity on WDATA and WSTRB.
// With the macro undefined, both parity outputs are tied to all-ones.
module msi_irq_axi_master #(
  parameter int          DATA_W     = 256,
  parameter int          NUM_VEC    = 8,
  parameter logic [7:0]  AXI_ID     = 8'h00,
  parameter logic [87:0] AWUSER_MSI = {1'b1, 63'b0, 24'h000002}
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      cfg_msi_en,
  input  logic [63:0]                               cfg_msi_addr,
  input  logic [15:0]                               cfg_msi_data,
  input  logic [2:0]                                cfg_mme,
  input  logic [NUM_VEC-1:0]                        irq_req,
  input  logic [NUM_VEC-1:0]                        irq_mask,
  output logic [NUM_VEC-1:0]                        irq_pending,
  output logic [1:0]                                state,
  output logic [15:0]                               err_cnt,
  output logic [4:0]                                last_err_vec,
  output logic [63:0]                               MASTER_AXI_AWADDR,
  output logic [7:0]                                MASTER_AXI_AWID,
  output logic [7:0]                                MASTER_AXI_AWLEN,
  output logic [2:0]                                MASTER_AXI_AWSIZE,
  output logic [87:0]                               MASTER_AXI_AWUSER,
  output logic                                      MASTER_AXI_AWVALID,
  input  logic                                      MASTER_AXI_AWREADY,
  output logic [DATA_W-1:0]                         MASTER_AXI_WDATA,
  output logic [DATA_W/8-1:0]                       MASTER_AXI_WDATA_PAR,
  output logic [DATA_W/8-1:0]                       MASTER_AXI_WSTRB,
  output logic [((DATA_W >= 64) ? DATA_W/64 : 1)-1:0] MASTER_AXI_WSTRB_PAR,
  output logic                                      MASTER_AXI_WLAST,
  output logic                                      MASTER_AXI_WVALID,
  input  logic                                      MASTER_AXI_WREADY,
  input  logic [7:0]                                MASTER_AXI_BID,
  input  logic [1:0]                                MASTER_AXI_BRESP,
  input  logic                                      MASTER_AXI_BVALID,
  output logic                                      MASTER_AXI_BREADY
);

  localparam int         BYTES   = DATA_W / 8;
  localparam int         OFF_W   = $clog2(BYTES);
  localparam int         SP_W    = (DATA_W >= 64) ? DATA_W / 64 : 1;
  localparam logic [2:0] AW_SIZE = 3'(OFF_W);
  localparam logic [5:0] NV6     = 6'(NUM_VEC);
  localparam logic [NUM_VEC-1:0] VEC_ONE = (NUM_VEC)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_B = 2'd2} state_t;

  state_t               state_reg, state_next;
  logic [NUM_VEC-1:0]   req_q_reg, pending_reg, pending_next;
  logic [NUM_VEC-1:0]   rise, cand, cand_rot, clr;
  logic [2*NUM_VEC-1:0] cand_dbl;
  logic [4:0]           rr_ptr_reg, grant_reg, grant_idx, grant_off, rr_ptr_next;
  logic [5:0]           grant_sum, ptr_sum;
  logic                 grant_found, grant_fire, b_fire, aw_done, w_done;
  logic [2:0]           mme_eff;
  logic [15:0]          msg_mask, msg;
  logic [63:0]          addr_al;
  logic [OFF_W-1:0]     off;
  logic [DATA_W-1:0]    wdata_next;
  logic [BYTES-1:0]     wstrb_next;

  logic [63:0]          awaddr_reg;
  logic [7:0]           awid_reg;
  logic [2:0]           awsize_reg;
  logic [87:0]          awuser_reg;
  logic                 awvalid_reg, wvalid_reg, wlast_reg;
  logic [DATA_W-1:0]    wdata_reg;
  logic [BYTES-1:0]     wstrb_reg;
  logic [15:0]          err_cnt_reg;
  logic [4:0]           last_err_vec_reg;

  // BID is deliberately ignored and address bits [1:0] are forced to zero.
  logic unused_ok;
  assign unused_ok = ^{MASTER_AXI_BID, cfg_msi_addr[1:0]};

  assign rise   = irq_req & ~req_q_reg;
  assign cand   = pending_reg & ~irq_mask;
  assign b_fire = (state_reg == WAIT_B) && MASTER_AXI_BVALID;

  // Round-robin pick: rotate candidates so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    cand_dbl    = {cand, cand} >> rr_ptr_reg;
    cand_rot    = cand_dbl[NUM_VEC-1:0];
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = NUM_VEC - 1; k >= 0; k--) begin
      if (cand_rot[k]) begin
        grant_found = 1'b1;
        grant_off   = 5'(k);
      end
    end
    grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
    if (grant_sum >= NV6) grant_sum = grant_sum - NV6;
    grant_idx = grant_sum[4:0];
    ptr_sum   = {1'b0, grant_idx} + 6'd1;
    if (ptr_sum >= NV6) ptr_sum = ptr_sum - NV6;
    rr_ptr_next = ptr_sum[4:0];
    grant_fire  = (state_reg == IDLE) && cfg_msi_en && grant_found;
  end

  // Message payload: low mme bits of the base data carry the vector number.
  always_comb begin
    mme_eff    = (cfg_mme > 3'd5) ? 3'd5 : cfg_mme;
    msg_mask   = (16'd1 << mme_eff) - 16'd1;
    msg        = (cfg_msi_data & ~msg_mask) | ({11'b0, grant_idx} & msg_mask);
    addr_al    = {cfg_msi_addr[63:2], 2'b00};
    off        = addr_al[OFF_W-1:0];
    wdata_next = {{(DATA_W-16){1'b0}}, msg} << {off, 3'b000};
    wstrb_next = {{(BYTES-2){1'b0}}, 2'b11} << off;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state: leave ISSUE only once both AW and W have handshaked.
  always_comb begin
    state_next = state_reg;
    aw_done    = !awvalid_reg || MASTER_AXI_AWREADY;
    w_done     = !wvalid_reg  || MASTER_AXI_WREADY;
    unique case (state_reg)
      IDLE:    if (grant_fire) state_next = ISSUE;
      ISSUE:   if (aw_done && w_done) state_next = WAIT_B;
      WAIT_B:  if (MASTER_AXI_BVALID) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pending bits: a new rising edge wins over the completion clear.
  always_comb begin
    clr          = b_fire ? (VEC_ONE << grant_reg) : '0;
    pending_next = (pending_reg & ~clr) | rise;
  end

  // Request edge history and pending register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q_reg   <= '0;
      pending_reg <= '0;
    end else begin
      req_q_reg   <= irq_req;
      pending_reg <= pending_next;
    end
  end

  // Latch the write at grant; each VALID drops on its own handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awaddr_reg  <= '0;
      awid_reg    <= '0;
      awsize_reg  <= '0;
      awuser_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      wlast_reg   <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      grant_reg   <= '0;
      rr_ptr_reg  <= '0;
    end else if (grant_fire) begin
      awaddr_reg  <= addr_al;
      awid_reg    <= AXI_ID;
      awsize_reg  <= AW_SIZE;
      awuser_reg  <= AWUSER_MSI;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      wlast_reg   <= 1'b1;
      awvalid_reg <= 1'b1;
      wvalid_reg  <= 1'b1;
      grant_reg   <= grant_idx;
      rr_ptr_reg  <= rr_ptr_next;
    end else begin
      if (awvalid_reg && MASTER_AXI_AWREADY) awvalid_reg <= 1'b0;
      if (wvalid_reg && MASTER_AXI_WREADY)   wvalid_reg  <= 1'b0;
    end
  end

  // Error accounting on non-OKAY write responses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_reg      <= '0;
      last_err_vec_reg <= '0;
    end else if (b_fire && (MASTER_AXI_BRESP != 2'b00)) begin
      if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
      last_err_vec_reg <= grant_reg;
    end
  end

`ifdef MSI_AXI_PARITY_EN
  // Odd parity per data byte and per group of eight strobes.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_wdata_par
    assign MASTER_AXI_WDATA_PAR[gi] = ~^wdata_reg[8*gi +: 8];
  end
  if (DATA_W >= 64) begin : g_wstrb_par_wide
    for (genvar gi = 0; gi < SP_W; gi++) begin : g_wstrb_par
      assign MASTER_AXI_WSTRB_PAR[gi] = ~^wstrb_reg[8*gi +: 8];
    end
  end else begin : g_wstrb_par_narrow
    assign MASTER_AXI_WSTRB_PAR = ~^wstrb_reg;
  end
`else
  assign MASTER_AXI_WDATA_PAR = '1;
  assign MASTER_AXI_WSTRB_PAR = '1;
`endif

  assign irq_pending        = pending_reg;
  assign state              = state_reg;
  assign err_cnt            = err_cnt_reg;
  assign last_err_vec       = last_err_vec_reg;
  assign MASTER_AXI_AWADDR  = awaddr_reg;
  assign MASTER_AXI_AWID    = awid_reg;
  assign MASTER_AXI_AWLEN   = 8'd0;
  assign MASTER_AXI_AWSIZE  = awsize_reg;
  assign MASTER_AXI_AWUSER  = awuser_reg;
  assign MASTER_AXI_AWVALID = awvalid_reg;
  assign MASTER_AXI_WDATA   = wdata_reg;
  assign MASTER_AXI_WSTRB   = wstrb_reg;
  assign MASTER_AXI_WLAST   = wlast_reg;
  assign MASTER_AXI_WVALID  = wvalid_reg;
  assign MASTER_AXI_BREADY  = (state_reg == WAIT_B);

endmodule

// File: tb/tb_msi_irq_axi_master.sv
// Testbench for msi_irq_axi_master: directed table of single-vector MSIs
// plus hand sequences for ordering, back-pressure, masking, set/clear
// collision and asynchronous reset.
module tb_msi_irq_axi_master;
  localparam int DATA_W  = 256;
  localparam int NUM_VEC = 8;
  localparam logic [87:0] EXP_USER = {1'b1, 63'b0, 24'h000002};
  localparam logic [63:0] EXP_ADDR = 64'h0000_0000_FEE0_0024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn;
  logic               cfg_msi_en;
  logic [63:0]        cfg_msi_addr;
  logic [15:0]        cfg_msi_data;
  logic [2:0]         cfg_mme;
  logic [NUM_VEC-1:0] irq_req, irq_mask, irq_pending;
  logic [1:0]         state;
  logic [15:0]        err_cnt;
  logic [4:0]         last_err_vec;
  logic [63:0]        awaddr;
  logic [7:0]         awid, awlen;
  logic [2:0]         awsize;
  logic [87:0]        awuser;
  logic               awvalid, awready;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W/8-1:0] wdata_par, wstrb;
  logic [DATA_W/64-1:0] wstrb_par;
  logic               wlast, wvalid, wready;
  logic [7:0]         bid;
  logic [1:0]         bresp;
  logic               bvalid, bready;

  msi_irq_axi_master #(.DATA_W(DATA_W), .NUM_VEC(NUM_VEC)) dut (
    .clk(clk), .rstn(rstn), .cfg_msi_en(cfg_msi_en), .cfg_msi_addr(cfg_msi_addr),
    .cfg_msi_data(cfg_msi_data), .cfg_mme(cfg_mme), .irq_req(irq_req),
    .irq_mask(irq_mask), .irq_pending(irq_pending), .state(state),
    .err_cnt(err_cnt), .last_err_vec(last_err_vec),
    .MASTER_AXI_AWADDR(awaddr), .MASTER_AXI_AWID(awid), .MASTER_AXI_AWLEN(awlen),
    .MASTER_AXI_AWSIZE(awsize), .MASTER_AXI_AWUSER(awuser),
    .MASTER_AXI_AWVALID(awvalid), .MASTER_AXI_AWREADY(awready),
    .MASTER_AXI_WDATA(wdata), .MASTER_AXI_WDATA_PAR(wdata_par),
    .MASTER_AXI_WSTRB(wstrb), .MASTER_AXI_WSTRB_PAR(wstrb_par),
    .MASTER_AXI_WLAST(wlast), .MASTER_AXI_WVALID(wvalid), .MASTER_AXI_WREADY(wready),
    .MASTER_AXI_BID(bid), .MASTER_AXI_BRESP(bresp), .MASTER_AXI_BVALID(bvalid),
    .MASTER_AXI_BREADY(bready)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          vec;
    logic [2:0]  mme;
    logic [15:0] data;
    logic [1:0]  resp;
    logic [15:0] exp_msg;
    logic [15:0] exp_err;
    logic [4:0]  exp_last;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; the request is high across exactly one posedge.
  task automatic pulse(input logic [NUM_VEC-1:0] bits);
    irq_req = irq_req | bits;
    @(negedge clk);
    irq_req = irq_req & ~bits;
  endtask

  task automatic wait_aw(input string tag, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (awvalid === 1'b1) ok = 1'b1;
    end
    chk({tag, " awvalid"}, 256'(ok), 256'(1));
  endtask

  task automatic check_fields(input string tag, input logic [15:0] msg);
    logic [255:0] exp_wdata;
    exp_wdata = 256'(msg) << 32;
    chk({tag, " awaddr"}, 256'(awaddr), 256'(EXP_ADDR));
    chk({tag, " awsize"}, 256'(awsize), 256'(5));
    chk({tag, " awlen"}, 256'(awlen), 256'(0));
    chk({tag, " awid"}, 256'(awid), 256'(0));
    chk({tag, " awuser"}, 256'(awuser), 256'(EXP_USER));
    chk({tag, " wstrb"}, 256'(wstrb), 256'(32'h30));
    chk({tag, " wdata"}, wdata, exp_wdata);
    chk({tag, " wlast"}, 256'(wlast), 256'(1));
    chk({tag, " wvalid"}, 256'(wvalid), 256'(1));
  endtask

  // Caller is at a negedge with state WAIT_B.
  task automatic finish_b(input string tag, input logic [1:0] resp);
    bvalid = 1'b1;
    bresp  = resp;
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = 2'b00;
    chk({tag, " idle"}, 256'(state), 256'(0));
    chk({tag, " bready low"}, 256'(bready), 256'(0));
  endtask

  task automatic run_msi(input string tag, input int vec, input logic [15:0] msg,
                         input logic [1:0] resp, input int max_lat);
    int cyc;
    bit ok;
    wait_aw(tag, cyc, ok);
    if (!ok) return;
    if (max_lat > 0) chk({tag, " latency"}, 256'(cyc <= max_lat), 256'(1));
    check_fields(tag, msg);
    @(negedge clk);
    chk({tag, " wait_b"}, 256'(state), 256'(2));
    chk({tag, " bready"}, 256'(bready), 256'(1));
    chk({tag, " valids low"}, 256'({awvalid, wvalid}), 256'(0));
    finish_b(tag, resp);
    chk({tag, " pending clr"}, 256'(irq_pending[vec]), 256'(0));
    $display("[TB] %s vec=%0d msg=%h resp=%0d done", tag, vec, msg, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit ok;
    rstn = 1'b0; cfg_msi_en = 1'b1; cfg_msi_addr = EXP_ADDR; cfg_msi_data = 16'h4000;
    cfg_mme = 3'd0; irq_req = '0; irq_mask = '0; awready = 1'b1; wready = 1'b1;
    bid = 8'h00; bresp = 2'b00; bvalid = 1'b0;

    tbl[0] = '{0, 3'd0, 16'h4000, 2'b00, 16'h4000, 16'd0, 5'd0};
    tbl[1] = '{3, 3'd2, 16'h4000, 2'b00, 16'h4003, 16'd0, 5'd0};
    tbl[2] = '{6, 3'd3, 16'h4008, 2'b00, 16'h400E, 16'd0, 5'd0};
    tbl[3] = '{3, 3'd0, 16'h4000, 2'b10, 16'h4000, 16'd1, 5'd3};
    tbl[4] = '{7, 3'd7, 16'hABFF, 2'b00, 16'hABE7, 16'd1, 5'd3};
    tbl[5] = '{1, 3'd1, 16'h1234, 2'b00, 16'h1235, 16'd1, 5'd3};
    tbl[6] = '{5, 3'd3, 16'h4000, 2'b11, 16'h4005, 16'd2, 5'd5};
    tbl[7] = '{4, 3'd5, 16'h0000, 2'b01, 16'h0004, 16'd3, 5'd4};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst state", 256'(state), 256'(0));
    chk("rst pending", 256'(irq_pending), 256'(0));
    chk("rst valids", 256'({awvalid, wvalid, bready}), 256'(0));
    chk("rst awaddr", 256'(awaddr), 256'(0));
    chk("rst awsize", 256'(awsize), 256'(0));
    chk("rst awuser", 256'(awuser), 256'(0));
    chk("rst wdata", wdata, 256'(0));
    chk("rst wstrb", 256'(wstrb), 256'(0));
    chk("rst wlast", 256'(wlast), 256'(0));
    chk("rst err", 256'({err_cnt, last_err_vec}), 256'(0));
    chk("rst wdata_par", 256'(wdata_par), 256'(32'hFFFF_FFFF));
    chk("rst wstrb_par", 256'(wstrb_par), 256'(4'hF));
    rstn = 1'b1;
    @(negedge clk);

    // Two-edge latency from request to VALID.
    pulse(8'h01);
    chk("lat pending", 256'(irq_pending), 256'(8'h01));
    chk("lat no aw yet", 256'(awvalid), 256'(0));
    run_msi("lat", 0, 16'h4000, 2'b00, 1);

    // Three vectors in one cycle, served in round-robin order.
    cfg_mme = 3'd3;
    pulse(8'hA4);
    run_msi("rr0", 2, 16'h4002, 2'b00, 0);
    run_msi("rr1", 5, 16'h4005, 2'b00, 1);
    run_msi("rr2", 7, 16'h4007, 2'b00, 1);

    // Table of single-vector MSIs.
    for (int i = 0; i < 8; i++) begin
      cfg_mme = tbl[i].mme;
      cfg_msi_data = tbl[i].data;
      pulse(NUM_VEC'(1) << tbl[i].vec);
      run_msi($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].exp_msg, tbl[i].resp, 1);
      chk($sformatf("tbl%0d err_cnt", i), 256'(err_cnt), 256'(tbl[i].exp_err));
      chk($sformatf("tbl%0d last_err", i), 256'(last_err_vec), 256'(tbl[i].exp_last));
    end
    cfg_mme = 3'd3;
    cfg_msi_data = 16'h4000;

    // Pointer sits at 5 after vector 4: order must wrap 5, 1, 3.
    pulse(8'h2A);
    run_msi("wrap0", 5, 16'h4005, 2'b00, 0);
    run_msi("wrap1", 1, 16'h4001, 2'b00, 1);
    run_msi("wrap2", 3, 16'h4003, 2'b00, 1);

    // AW back-pressure: W completes first, WAIT_B only after AW.
    awready = 1'b0;
    pulse(8'h01);
    wait_aw("bp", cyc, ok);
    if (ok) begin
      check_fields("bp", 16'h4000);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk($sformatf("bp%0d aw held", i), 256'(awvalid), 256'(1));
        chk($sformatf("bp%0d w dropped", i), 256'(wvalid), 256'(0));
        chk($sformatf("bp%0d issue", i), 256'(state), 256'(1));
      end
      awready = 1'b1;
      @(negedge clk);
      chk("bp aw dropped", 256'(awvalid), 256'(0));
      chk("bp wait_b", 256'(state), 256'(2));
      finish_b("bp", 2'b00);
      chk("bp pending clr", 256'(irq_pending[0]), 256'(0));
      $display("[TB] bp vec=0 back-pressure done");
    end

    // Masked vector stays pending; address bits [1:0] ignored.
    cfg_msi_addr = 64'h0000_0000_FEE0_0027;
    irq_mask = 8'h02;
    pulse(8'h02);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mask%0d no aw", i), 256'(awvalid), 256'(0));
    end
    chk("mask pending", 256'(irq_pending[1]), 256'(1));
    irq_mask = 8'h00;
    run_msi("mask", 1, 16'h4001, 2'b00, 2);
    cfg_msi_addr = EXP_ADDR;

    // New edge in the BVALID cycle re-arms the same vector.
    pulse(8'h10);
    wait_aw("col", cyc, ok);
    if (ok) begin
      @(negedge clk);
      chk("col wait_b", 256'(state), 256'(2));
      irq_req = 8'h10;
      bvalid = 1'b1;
      @(negedge clk);
      bvalid = 1'b0;
      irq_req = 8'h00;
      chk("col idle", 256'(state), 256'(0));
      chk("col pending kept", 256'(irq_pending[4]), 256'(1));
      run_msi("col refire", 4, 16'h4004, 2'b00, 1);
    end

    // Asynchronous reset while in ISSUE.
    awready = 1'b0;
    pulse(8'h08);
    wait_aw("rst", cyc, ok);
    if (ok) begin
      #2 rstn = 1'b0;
      #1;
      chk("arst valids", 256'({awvalid, wvalid, bready}), 256'(0));
      chk("arst state", 256'(state), 256'(0));
      chk("arst pending", 256'(irq_pending), 256'(0));
      chk("arst wdata", wdata, 256'(0));
      chk("arst wdata_par", 256'(wdata_par), 256'(32'hFFFF_FFFF));
      chk("arst err", 256'(err_cnt), 256'(0));
      @(negedge clk);
      awready = 1'b1;
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst stays idle", 256'({state, awvalid}), 256'(0));
      $display("[TB] async reset in ISSUE done");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
